hero_burst_rx: RTL and testbench
================================

// Module: hero_burst_rx
// PURPOSE
//  Receive side of the hero write bus. Per clock, samples a test_pkg_a::CYCLE_TYPE_E tag plus a
//  test_pkg_a::hero_write_t beat; assembles VALID beats up to a DONE tag into one burst.
//  Presents the burst as a packed array of hero_write_t with valid/ready to the consumer.
//  The hero bus has no backpressure, so the block double-buffers: one slot assembles, one holds.
// PARAMETERS
//  MAX_BEATS  2                        max VALID beats per burst (>=1)
//  CNT_W      $clog2(MAX_BEATS+1)      beat-count width (derived; do not override)
// PORTS
//  clk        in   1                   sole clock; all logic on posedge
//  rst_n      in   1                   synchronous, active-low reset
//  hero_cyc   in   CYCLE_TYPE_E        IDLE / VALID / DONE tag for this cycle
//  hero_wr    in   $bits(hero_write_t) write beat; meaningful only when hero_cyc==VALID
//  burst_vld  out  1                   burst_data/burst_cnt hold a completed burst
//  burst_rdy  in   1                   consumer accepts when burst_vld & burst_rdy
//  burst_data out  hero_write_t[MAX_BEATS] beat i in element i; unused elements are 0
//  burst_cnt  out  CNT_W               number of valid beats, 1..MAX_BEATS
//  ovf_err    out  1                   1-cycle pulse: burst exceeded MAX_BEATS, discarded
//  drop_err   out  1                   1-cycle pulse: burst completed while hold slot full, dropped
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): FSM->IDLE; beat count 0; assembly and hold slots cleared;
//   burst_vld=0, burst_data=0, burst_cnt=0, ovf_err=0, drop_err=0. A burst partly assembled
//   at reset is lost; no error pulses.
//  FSM states IDLE, COLLECT, DISCARD:
//   IDLE:    VALID -> store beat at idx0, cnt=1, ->COLLECT. IDLE tag/DONE -> stay, no output.
//   COLLECT: VALID with cnt<MAX_BEATS -> store at idx cnt, cnt++. VALID with cnt==MAX_BEATS
//            -> pulse ovf_err next cycle, clear assembly, ->DISCARD. IDLE tag -> hold (gap
//            allowed). DONE -> complete burst (DONE carries no data), ->IDLE.
//   DISCARD: ignore beats until DONE -> IDLE; no burst emitted; ovf_err pulses once only.
//  Completion: hold slot empty, or handshake in same cycle -> assembly copied to hold,
//   burst_vld=1 next cycle. Latency DONE edge -> burst_vld = 1 cycle. Hold full, no
//   handshake -> burst dropped, drop_err pulses next cycle, hold unchanged.
//  Handshake: burst_data/burst_cnt stable while burst_vld & !burst_rdy. burst_vld falls the
//   cycle after accept unless a new burst completes in that accept cycle (back-to-back,
//   no bubble). Max throughput: one burst per MAX_BEATS+1 cycles.
//  Empty burst (DONE in IDLE): silently ignored, not an error.
//  VALID right after DONE is legal: it starts the next burst in the DONE+1 cycle.
//  Unknown/illegal tag encodings are treated as IDLE.
// CONFIGURATION
//  HERO_BURST_RX_STATS_EN defined: adds outputs stat_bursts[15:0], stat_ovf[7:0], stat_drop[7:0].
//   Each increments on burst accept, ovf_err and drop_err respectively, saturating at
//   all-ones; reset to 0.
//  Not defined: the ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
//  Shared package test_pkg_b: typedef enum {HBR_IDLE,HBR_COLLECT,HBR_DISCARD} hbr_state_e;
//   typedef test_pkg_a::hero_write_t [MAX_BEATS-1:0] hero_burst_t; localparam HBR_MAX_BEATS=2.
//  One sub-module: hero_burst_hold, a single-entry valid/ready register slice for the hold
//   slot (load, accept, full). FSM and assembly logic in the top level.
// TESTING
//  1 VALID(A),VALID(B),DONE, rdy=1 -> burst_vld 1 cycle after DONE, cnt=2, data={B,A}.
//  2 VALID(A),IDLE,IDLE,DONE -> cnt=1, data[0]=A, data[1]=0; gaps do not break the burst.
//  3 VALID x3, DONE (MAX_BEATS=2) -> ovf_err pulses once, no burst_vld; next VALID(C),DONE
//    -> cnt=1, data[0]=C.
//  4 rdy=0; burst1 done, then burst2 done -> drop_err=1, burst1 data unchanged; raise rdy ->
//    burst1 accepted, burst_vld=0.
//  5 rdy=1; back-to-back VALID,DONE,VALID,DONE -> two bursts, burst_vld never gaps when
//    accept and completion coincide.
//  6 rst_n=0 mid-COLLECT after 1 VALID, then DONE -> no burst, no error; STATS_EN build:
//    stat_bursts/stat_ovf/stat_drop counted and reset to 0.

Source files
------------

// File: rtl/test_pkg_a.sv
`default_nettype none
// ---------------------------------------------------------------------------
// test_pkg_a : hero write bus cycle tag and beat types   (rev 1.0)
// ---------------------------------------------------------------------------
package test_pkg_a;

    // Encoding 2'd3 is unused on the bus and is received as an idle cycle.
    typedef enum logic [1:0] {
        CYC_IDLE  = 2'd0,
        CYC_VALID = 2'd1,
        CYC_DONE  = 2'd2
    } CYCLE_TYPE_E;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] data;
    } hero_write_t;

endpackage
`default_nettype wire

// File: rtl/test_pkg_b.sv
`default_nettype none
// ---------------------------------------------------------------------------
// test_pkg_b : burst receiver state, burst container and sizing   (rev 1.0)
// ---------------------------------------------------------------------------
package test_pkg_b;

    localparam int HBR_MAX_BEATS = 2;

    typedef enum logic [1:0] {
        HBR_IDLE    = 2'd0,
        HBR_COLLECT = 2'd1,
        HBR_DISCARD = 2'd2
    } hbr_state_e;

    typedef test_pkg_a::hero_write_t [HBR_MAX_BEATS-1:0] hero_burst_t;

endpackage
`default_nettype wire

// File: rtl/hero_burst_hold.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hero_burst_hold : single-entry valid/ready slice holding a finished burst
// rev 1.0
// ---------------------------------------------------------------------------
module hero_burst_hold
    import test_pkg_a::*;
    import test_pkg_b::*;
#(
    parameter int MAX_BEATS = HBR_MAX_BEATS,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         load,
    input  hero_write_t [MAX_BEATS-1:0]  load_data,
    input  logic        [CNT_W-1:0]      load_cnt,
    input  logic                         rdy,
    output logic                         vld,
    output hero_write_t [MAX_BEATS-1:0]  data,
    output logic        [CNT_W-1:0]      cnt,
    output logic                         full,
    output logic                         accept
);

    logic                        r_vld;
    hero_write_t [MAX_BEATS-1:0] r_data;
    logic        [CNT_W-1:0]     r_cnt;

    assign accept = r_vld & rdy;
    assign full   = r_vld;
    assign vld    = r_vld;
    assign data   = r_data;
    assign cnt    = r_cnt;

    // A load in the accept cycle wins, giving back-to-back bursts without a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_cnt  <= '0;
        end else if (load) begin
            r_vld  <= 1'b1;
            r_data <= load_data;
            r_cnt  <= load_cnt;
        end else if (accept) begin
            r_vld  <= 1'b0;
            r_data <= '0;
            r_cnt  <= '0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hero_burst_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// hero_burst_rx : assembles hero bus beats into bursts, double-buffered output
// Optional HERO_BURST_RX_STATS_EN adds saturating burst/ovf/drop counters.
// rev 1.0
// ---------------------------------------------------------------------------
module hero_burst_rx
    import test_pkg_a::*;
    import test_pkg_b::*;
#(
    parameter int MAX_BEATS = HBR_MAX_BEATS,
    parameter int CNT_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  CYCLE_TYPE_E                  hero_cyc,
    input  hero_write_t                  hero_wr,
    output logic                         burst_vld,
    input  logic                         burst_rdy,
    output hero_write_t [MAX_BEATS-1:0]  burst_data,
    output logic        [CNT_W-1:0]      burst_cnt,
    output logic                         ovf_err,
    output logic                         drop_err
`ifdef HERO_BURST_RX_STATS_EN
    ,
    output logic        [15:0]           stat_bursts,
    output logic        [7:0]            stat_ovf,
    output logic        [7:0]            stat_drop
`endif
);

    hbr_state_e                  r_state;
    logic        [CNT_W-1:0]     r_cnt;
    hero_write_t [MAX_BEATS-1:0] r_asm;
    logic                        r_ovf;
    logic                        r_drop;

    logic w_is_valid;
    logic w_is_done;
    logic w_complete;
    logic w_full;
    logic w_accept;
    logic w_load;

    // Any encoding other than VALID/DONE falls through as an idle cycle.
    assign w_is_valid = (hero_cyc == CYC_VALID);
    assign w_is_done  = (hero_cyc == CYC_DONE);
    assign w_complete = (r_state == HBR_COLLECT) && w_is_done;
    assign w_load     = w_complete && (!w_full || w_accept);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= HBR_IDLE;
            r_cnt   <= '0;
            r_asm   <= '0;
            r_ovf   <= 1'b0;
            r_drop  <= 1'b0;
        end else begin
            r_ovf  <= 1'b0;
            r_drop <= 1'b0;
            case (r_state)
                HBR_IDLE: begin
                    if (w_is_valid) begin
                        r_asm[0] <= hero_wr;
                        r_cnt    <= CNT_W'(1);
                        r_state  <= HBR_COLLECT;
                    end
                end
                HBR_COLLECT: begin
                    if (w_is_valid) begin
                        if (r_cnt == CNT_W'(MAX_BEATS)) begin
                            r_ovf   <= 1'b1;
                            r_asm   <= '0;
                            r_cnt   <= '0;
                            r_state <= HBR_DISCARD;
                        end else begin
                            for (int i = 0; i < MAX_BEATS; i++) begin
                                if (r_cnt == CNT_W'(i)) begin
                                    r_asm[i] <= hero_wr;
                                end
                            end
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end else if (w_is_done) begin
                        // The hold slot takes r_asm this edge unless it is busy.
                        r_drop  <= !w_load;
                        r_asm   <= '0;
                        r_cnt   <= '0;
                        r_state <= HBR_IDLE;
                    end
                end
                HBR_DISCARD: begin
                    if (w_is_done) begin
                        r_state <= HBR_IDLE;
                    end
                end
                default: begin
                    r_state <= HBR_IDLE;
                end
            endcase
        end
    end

    hero_burst_hold #(
        .MAX_BEATS (MAX_BEATS),
        .CNT_W     (CNT_W)
    ) u_hold (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .load_data (r_asm),
        .load_cnt  (r_cnt),
        .rdy       (burst_rdy),
        .vld       (burst_vld),
        .data      (burst_data),
        .cnt       (burst_cnt),
        .full      (w_full),
        .accept    (w_accept)
    );

    assign ovf_err  = r_ovf;
    assign drop_err = r_drop;

`ifdef HERO_BURST_RX_STATS_EN
    logic [15:0] r_stat_bursts;
    logic [7:0]  r_stat_ovf;
    logic [7:0]  r_stat_drop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stat_bursts <= '0;
            r_stat_ovf    <= '0;
            r_stat_drop   <= '0;
        end else begin
            if (w_accept && (r_stat_bursts != '1)) r_stat_bursts <= r_stat_bursts + 16'd1;
            if (r_ovf    && (r_stat_ovf    != '1)) r_stat_ovf    <= r_stat_ovf + 8'd1;
            if (r_drop   && (r_stat_drop   != '1)) r_stat_drop   <= r_stat_drop + 8'd1;
        end
    end

    assign stat_bursts = r_stat_bursts;
    assign stat_ovf    = r_stat_ovf;
    assign stat_drop   = r_stat_drop;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hero_burst_rx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_hero_burst_rx : directed bench with a queue-based burst model   (rev 1.0)
// ---------------------------------------------------------------------------
module tb_hero_burst_rx;
    import test_pkg_a::*;
    import test_pkg_b::*;

    localparam int MB = HBR_MAX_BEATS;
    localparam int CW = $clog2(MB + 1);

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  burst_rdy = 1'b0;
    CYCLE_TYPE_E           hero_cyc = CYC_IDLE;
    hero_write_t           hero_wr = '0;
    logic                  burst_vld;
    hero_write_t [MB-1:0]  burst_data;
    logic [CW-1:0]         burst_cnt;
    logic                  ovf_err;
    logic                  drop_err;
`ifdef HERO_BURST_RX_STATS_EN
    logic [15:0]           stat_bursts;
    logic [7:0]            stat_ovf;
    logic [7:0]            stat_drop;
`endif

    always #5 clk = ~clk;

    hero_burst_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hero_cyc   (hero_cyc),
        .hero_wr    (hero_wr),
        .burst_vld  (burst_vld),
        .burst_rdy  (burst_rdy),
        .burst_data (burst_data),
        .burst_cnt  (burst_cnt),
        .ovf_err    (ovf_err),
        .drop_err   (drop_err)
`ifdef HERO_BURST_RX_STATS_EN
        ,
        .stat_bursts(stat_bursts),
        .stat_ovf   (stat_ovf),
        .stat_drop  (stat_drop)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a burst is the list of beats seen since its first VALID; the output
    // side is one slot that is either empty or holds a finished list.
    hero_write_t m_beats[$];
    bit          m_disc;
    bit          m_hv;
    hero_burst_t m_hdata;
    int          m_hcnt;
    bit          m_ovf;
    bit          m_drop;
    int          m_sb, m_so, m_sd;

    always @(posedge clk) begin
        bit acc;
        bit load;
        if (!rst_n) begin
            m_beats.delete();
            m_disc = 0; m_hv = 0; m_hdata = '0; m_hcnt = 0;
            m_ovf = 0; m_drop = 0;
            m_sb = 0; m_so = 0; m_sd = 0;
        end else begin
            acc = m_hv && burst_rdy;
            load = 0;
            if (acc && m_sb < 65535) m_sb++;
            if (m_ovf && m_so < 255) m_so++;
            if (m_drop && m_sd < 255) m_sd++;
            m_ovf = 0;
            m_drop = 0;
            if (m_disc) begin
                if (hero_cyc == CYC_DONE) m_disc = 0;
            end else if (hero_cyc == CYC_VALID) begin
                if (m_beats.size() == MB) begin
                    m_ovf = 1;
                    m_beats.delete();
                    m_disc = 1;
                end else begin
                    m_beats.push_back(hero_wr);
                end
            end else if (hero_cyc == CYC_DONE && m_beats.size() > 0) begin
                if (!m_hv || acc) begin
                    m_hdata = '0;
                    foreach (m_beats[i]) m_hdata[i] = m_beats[i];
                    m_hcnt = m_beats.size();
                    load = 1;
                end else begin
                    m_drop = 1;
                end
                m_beats.delete();
            end
            if (load) m_hv = 1;
            else if (acc) m_hv = 0;
        end
    end

    always @(negedge clk) begin
        check("burst_vld", 128'(burst_vld), 128'(m_hv));
        check("ovf_err", 128'(ovf_err), 128'(m_ovf));
        check("drop_err", 128'(drop_err), 128'(m_drop));
        if (m_hv) begin
            check("burst_cnt", 128'(burst_cnt), 128'(m_hcnt));
            check("burst_data", 128'(burst_data), 128'(m_hdata));
        end
`ifdef HERO_BURST_RX_STATS_EN
        check("stat_bursts", 128'(stat_bursts), 128'(m_sb));
        check("stat_ovf", 128'(stat_ovf), 128'(m_so));
        check("stat_drop", 128'(stat_drop), 128'(m_sd));
`endif
    end

    task automatic beat(input CYCLE_TYPE_E t, input hero_write_t w);
        hero_cyc = t;
        hero_wr  = w;
        @(posedge clk);
        #2;
    endtask

    hero_write_t A, B, C, D, G;

    initial begin
        A = '{addr: 16'h1000, data: 32'hAAAA_0001};
        B = '{addr: 16'h2000, data: 32'hBBBB_0002};
        C = '{addr: 16'h3000, data: 32'hCCCC_0003};
        D = '{addr: 16'h4000, data: 32'hDDDD_0004};
        G = '{addr: 16'hDEAD, data: 32'hBEEF_F00D};

        repeat (2) @(posedge clk);
        #2;
        check("rst_vld", 128'(burst_vld), 128'd0);
        check("rst_cnt", 128'(burst_cnt), 128'd0);
        check("rst_data", 128'(burst_data), 128'd0);
        check("rst_errs", 128'({ovf_err, drop_err}), 128'd0);
        rst_n = 1'b1;

        // Full-length burst, consumer ready
        burst_rdy = 1'b1;
        beat(CYC_VALID, A);
        beat(CYC_VALID, B);
        beat(CYC_DONE, G);
        check("s1_vld", 128'(burst_vld), 128'd1);
        check("s1_cnt", 128'(burst_cnt), 128'd2);
        check("s1_d0", 128'(burst_data[0]), 128'(A));
        check("s1_d1", 128'(burst_data[1]), 128'(B));
        beat(CYC_IDLE, G);
        check("s1_vld_fall", 128'(burst_vld), 128'd0);

        // Idle gaps inside a burst, garbage on the bus when not VALID
        beat(CYC_VALID, A);
        beat(CYC_IDLE, G);
        beat(CYC_IDLE, G);
        beat(CYC_DONE, G);
        check("s2_cnt", 128'(burst_cnt), 128'd1);
        check("s2_d0", 128'(burst_data[0]), 128'(A));
        check("s2_d1", 128'(burst_data[1]), 128'd0);
        beat(CYC_IDLE, G);

        // Overflow then recovery
        beat(CYC_VALID, A);
        beat(CYC_VALID, B);
        beat(CYC_VALID, C);
        check("s3_ovf", 128'(ovf_err), 128'd1);
        beat(CYC_VALID, D);
        check("s3_ovf_once", 128'(ovf_err), 128'd0);
        beat(CYC_DONE, G);
        check("s3_no_vld", 128'(burst_vld), 128'd0);
        beat(CYC_VALID, C);
        beat(CYC_DONE, G);
        check("s3_cnt", 128'(burst_cnt), 128'd1);
        check("s3_d0", 128'(burst_data[0]), 128'(C));
        beat(CYC_IDLE, G);

        // Hold full, second burst dropped
        burst_rdy = 1'b0;
        beat(CYC_VALID, A);
        beat(CYC_DONE, G);
        beat(CYC_VALID, B);
        beat(CYC_DONE, G);
        check("s4_drop", 128'(drop_err), 128'd1);
        check("s4_d0", 128'(burst_data[0]), 128'(A));
        beat(CYC_IDLE, G);
        check("s4_drop_pulse", 128'(drop_err), 128'd0);
        burst_rdy = 1'b1;
        beat(CYC_IDLE, G);
        check("s4_vld_fall", 128'(burst_vld), 128'd0);

        // Completion coinciding with accept keeps burst_vld high
        burst_rdy = 1'b0;
        beat(CYC_VALID, A);
        beat(CYC_DONE, G);
        beat(CYC_VALID, B);
        burst_rdy = 1'b1;
        beat(CYC_DONE, G);
        check("s5_vld", 128'(burst_vld), 128'd1);
        check("s5_d0", 128'(burst_data[0]), 128'(B));
        beat(CYC_VALID, C);
        beat(CYC_DONE, G);
        beat(CYC_VALID, D);
        beat(CYC_DONE, G);
        check("s5_d0_last", 128'(burst_data[0]), 128'(D));
        beat(CYC_IDLE, G);

        // Reset mid-collect, then illegal tag treated as idle
        beat(CYC_VALID, A);
        rst_n = 1'b0;
        beat(CYC_IDLE, G);
        rst_n = 1'b1;
        beat(CYC_DONE, G);
        check("s6_no_vld", 128'(burst_vld), 128'd0);
        check("s6_no_err", 128'({ovf_err, drop_err}), 128'd0);
        beat(CYC_VALID, D);
        beat(CYCLE_TYPE_E'(2'd3), G);
        beat(CYC_DONE, G);
        check("s6_ill_cnt", 128'(burst_cnt), 128'd1);
        check("s6_ill_d0", 128'(burst_data[0]), 128'(D));
        repeat (3) beat(CYC_IDLE, G);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
